window_accum: RTL and testbench

WINDOW_ACCUM -- requirements
Module: window_accum

---
 rtl/window_accum.sv | 146 ++++++++++++++
 tb/tb_window_accum.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_accum.sv
// Multi-channel sliding-window accumulator with a valid/ready stream on both sides.
// Optional build macro WINDOW_ACCUM_AVG_EN turns the window sum into a rounded average.
module window_accum #(
    parameter  int DATA_WIDTH = 12,
    parameter  int POOL_SIZE  = 10,
    parameter  int STRIDE     = 1,
    parameter  int CHANNELS   = 4,
    localparam int ACC_WIDTH  = DATA_WIDTH + $clog2(POOL_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    output logic                           in_ready,
    input  logic                           in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [CHANNELS*ACC_WIDTH-1:0]  out_data
);

    localparam int LOG2_POOL = $clog2(POOL_SIZE);
    localparam int PTR_W     = LOG2_POOL;
    localparam int CNT_W     = $clog2(POOL_SIZE + 1);
    localparam int STR_W     = $clog2(STRIDE + 1);

    localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(POOL_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(POOL_SIZE);
    localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'(POOL_SIZE - 1);
    localparam logic [STR_W-1:0] LAST_STRIDE = STR_W'(STRIDE - 1);

    if (POOL_SIZE < 2 || POOL_SIZE > 256) begin : g_bad_pool
        $error("window_accum: POOL_SIZE must be within 2..256");
    end
    if (STRIDE < 1 || STRIDE > POOL_SIZE) begin : g_bad_stride
        $error("window_accum: STRIDE must be within 1..POOL_SIZE");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("window_accum: CHANNELS must be within 1..16");
    end

`ifdef WINDOW_ACCUM_AVG_EN
    if ((1 << LOG2_POOL) != POOL_SIZE) begin : g_bad_avg_pool
        $error("window_accum: averaging needs POOL_SIZE to be a power of two");
    end
    localparam logic signed [ACC_WIDTH:0] ROUND_BIAS = (ACC_WIDTH + 1)'(1) << (LOG2_POOL - 1);
`endif

    logic             r_out_valid;
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_fill;
    logic [STR_W-1:0] r_stride;
    logic             w_accept;
    logic             w_push;
    logic             w_full;
    logic             w_emit;

    assign in_ready  = out_ready | ~r_out_valid;
    assign out_valid = r_out_valid;
    assign w_accept  = in_valid & in_ready;
    // A beat accepted together with flush is swallowed: it neither enters the window nor emits.
    assign w_push    = w_accept & ~flush;
    assign w_full    = (r_fill == FULL_CNT);
    assign w_emit    = w_push & ((r_fill == FILL_LAST) | (w_full & (r_stride == LAST_STRIDE)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_fill      <= '0;
            r_stride    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (flush) begin
                r_ptr    <= '0;
                r_fill   <= '0;
                r_stride <= '0;
            end else if (w_accept) begin
                r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
                if (!w_full) begin
                    r_fill <= r_fill + 1'b1;
                end
                // Stride counting starts only once the window is full.
                if (w_emit) begin
                    r_stride <= '0;
                end else if (w_full) begin
                    r_stride <= r_stride + 1'b1;
                end
            end
            if (w_emit) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
        logic        [DATA_WIDTH-1:0] r_win [POOL_SIZE];
        logic signed [ACC_WIDTH-1:0]  r_sum;
        logic signed [ACC_WIDTH-1:0]  r_out;
        logic        [DATA_WIDTH-1:0] w_sample;
        logic        [DATA_WIDTH-1:0] w_oldest;
        logic signed [ACC_WIDTH-1:0]  w_new;
        logic signed [ACC_WIDTH-1:0]  w_old;
        logic signed [ACC_WIDTH-1:0]  w_sum_next;
        logic signed [ACC_WIDTH-1:0]  w_out_val;

        assign w_sample = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        // The slot about to be overwritten holds the oldest sample, or zero while filling.
        assign w_oldest = r_win[r_ptr];
        assign w_new    = {{(ACC_WIDTH - DATA_WIDTH){w_sample[DATA_WIDTH-1]}}, w_sample};
        assign w_old    = {{(ACC_WIDTH - DATA_WIDTH){w_oldest[DATA_WIDTH-1]}}, w_oldest};
        assign w_sum_next = r_sum + w_new - w_old;

`ifdef WINDOW_ACCUM_AVG_EN
        logic signed [ACC_WIDTH:0] w_round;
        assign w_round   = {w_sum_next[ACC_WIDTH-1], w_sum_next} + ROUND_BIAS;
        assign w_out_val = ACC_WIDTH'(w_round >>> LOG2_POOL);
`else
        assign w_out_val = w_sum_next;
`endif

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                for (int i = 0; i < POOL_SIZE; i++) begin
                    r_win[i] <= '0;
                end
                r_sum <= '0;
            end else if (w_accept) begin
                r_win[r_ptr] <= w_sample;
                r_sum        <= w_sum_next;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_out <= '0;
            end else if (w_emit) begin
                r_out <= w_out_val;
            end
        end

        assign out_data[gi*ACC_WIDTH +: ACC_WIDTH] = r_out;
    end

endmodule

// File: tb/tb_window_accum.sv
// Self-checking bench for window_accum: two instances (defaults, and POOL 4 / STRIDE 3)
// share one stimulus stream and are checked against a sample-history reference model.
module tb_window_accum;

    localparam int NCH = 4;
    localparam int DW  = 12;
`ifdef WINDOW_ACCUM_AVG_EN
    localparam int PA  = 8;
`else
    localparam int PA  = 10;
`endif
    localparam int SA  = 1;
    localparam int PB  = 4;
    localparam int SB  = 3;
    localparam int AWA = DW + $clog2(PA);
    localparam int AWB = DW + $clog2(PB);

    typedef int lanes_t[NCH];

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 in_valid;
    logic                 out_ready;
    logic [NCH*DW-1:0]    in_data;
    logic                 a_in_ready, a_out_valid;
    logic [NCH*AWA-1:0]   a_out_data;
    logic                 b_in_ready, b_out_valid;
    logic [NCH*AWB-1:0]   b_out_data;

    window_accum #(.DATA_WIDTH(DW), .POOL_SIZE(PA), .STRIDE(SA), .CHANNELS(NCH)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_ready(a_in_ready), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(a_out_valid), .out_data(a_out_data)
    );

    window_accum #(.DATA_WIDTH(DW), .POOL_SIZE(PB), .STRIDE(SB), .CHANNELS(NCH)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_ready(b_in_ready), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(b_out_valid), .out_data(b_out_data)
    );

    always #5 clk = ~clk;

    // Reference model: accepted-sample history per lane and a count of beats since clear.
    int  hist[2][NCH][$];
    int  cnt[2];
    bit  exp_ov[2];
    int  exp_dat[2][NCH];
    bit  exp_rdy[2];
    bit  obs_rdy[2];
    int  pool_sz[2];
    int  stride_sz[2];
    int  n_tests = 0;
    int  n_fail  = 0;

    function automatic int lg2(int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int win_val(int d, int c);
        int s = 0;
        for (int i = 0; i < hist[d][c].size(); i++) s += hist[d][c][i];
`ifdef WINDOW_ACCUM_AVG_EN
        s = (s + (pool_sz[d] >> 1)) >>> lg2(pool_sz[d]);
`endif
        return s;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                hist[d][c].delete();
                exp_dat[d][c] = 0;
            end
            cnt[d]    = 0;
            exp_ov[d] = 1'b0;
        end
    endfunction

    function automatic void model_update(int d, bit acc, bit fl, bit ordy, lanes_t s);
        bit emit = 1'b0;
        if (fl) begin
            for (int c = 0; c < NCH; c++) hist[d][c].delete();
            cnt[d] = 0;
        end else if (acc) begin
            for (int c = 0; c < NCH; c++) begin
                hist[d][c].push_back(s[c]);
                if (hist[d][c].size() > pool_sz[d]) void'(hist[d][c].pop_front());
            end
            cnt[d]++;
            emit = (cnt[d] == pool_sz[d]) ||
                   (cnt[d] > pool_sz[d] && ((cnt[d] - pool_sz[d]) % stride_sz[d]) == 0);
        end
        if (emit) begin
            exp_ov[d] = 1'b1;
            for (int c = 0; c < NCH; c++) exp_dat[d][c] = win_val(d, c);
        end else if (ordy) begin
            exp_ov[d] = 1'b0;
        end
    endfunction

    function automatic int lane(int d, int c);
        if (d == 0) return int'($signed(a_out_data[c*AWA +: AWA]));
        return int'($signed(b_out_data[c*AWB +: AWB]));
    endfunction

    function automatic logic dut_ov(int d);
        return (d == 0) ? a_out_valid : b_out_valid;
    endfunction

    // Entered and left at posedge+1: drive one cycle, advance the model across the edge.
    task automatic step(input bit v, input bit fl, input bit ordy, input lanes_t s);
        in_valid  = v;
        flush     = fl;
        out_ready = ordy;
        for (int c = 0; c < NCH; c++) in_data[c*DW +: DW] = DW'(s[c]);
        for (int d = 0; d < 2; d++) exp_rdy[d] = ordy | ~exp_ov[d];
        @(negedge clk);
        obs_rdy[0] = a_in_ready;
        obs_rdy[1] = b_in_ready;
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_update(d, v & exp_rdy[d], fl, ordy, s);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic lanes_t rand_lanes();
        lanes_t s;
        for (int c = 0; c < NCH; c++) s[c] = int'($urandom_range(0, 4095)) - 2048;
        return s;
    endfunction

    task automatic test_reset();
        do_reset();
        out_ready = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (dut_ov(d) !== 1'b0) begin
                n_fail++; $display("FAIL reset_valid d%0d: got %0b want 0", d, dut_ov(d));
            end
            n_tests++;
            if (((d == 0) ? a_in_ready : b_in_ready) !== 1'b1) begin
                n_fail++; $display("FAIL reset_in_ready d%0d: got 0 want 1", d);
            end
            for (int c = 0; c < NCH; c++) begin
                n_tests++;
                if (lane(d, c) !== 0) begin
                    n_fail++; $display("FAIL reset_data d%0d ch%0d: got %0d want 0", d, c, lane(d, c));
                end
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_ones();
        int want;
`ifdef WINDOW_ACCUM_AVG_EN
        want = 1;
`else
        want = PA;
`endif
        do_reset();
        for (int i = 1; i <= PA + 4; i++) begin
            step(1'b1, 1'b0, 1'b1, '{1, 1, 1, 1});
            n_tests++;
            if (a_out_valid !== (i >= PA)) begin
                n_fail++; $display("FAIL ones_valid beat %0d: got %0b want %0b", i, a_out_valid, (i >= PA));
            end
            if (i >= PA) begin
                for (int c = 0; c < NCH; c++) begin
                    n_tests++;
                    if (lane(0, c) !== want) begin
                        n_fail++; $display("FAIL ones_data beat %0d ch%0d: got %0d want %0d", i, c, lane(0, c), want);
                    end
                end
            end
        end
        $display("[TB] test_ones done");
    endtask

    task automatic test_ramp();
        int  want;
        bit  want_v;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, 1'b1, '{i, i, i, i});
            want_v = (i == 4) || (i == 7) || (i == 10);
`ifdef WINDOW_ACCUM_AVG_EN
            want = (4 * i - 6 + 2) >>> 2;
`else
            want = 4 * i - 6;
`endif
            n_tests++;
            if (b_out_valid !== want_v) begin
                n_fail++; $display("FAIL ramp_valid beat %0d: got %0b want %0b", i, b_out_valid, want_v);
            end
            if (want_v) begin
                for (int c = 0; c < NCH; c++) begin
                    n_tests++;
                    if (lane(1, c) !== want) begin
                        n_fail++; $display("FAIL ramp_data beat %0d ch%0d: got %0d want %0d", i, c, lane(1, c), want);
                    end
                end
            end
        end
        $display("[TB] test_ramp done");
    endtask

    task automatic test_extremes();
        int want_a, want_b;
`ifdef WINDOW_ACCUM_AVG_EN
        want_a = -2048; want_b = -2048;
`else
        want_a = -2048 * PA; want_b = -2048 * PB;
`endif
        do_reset();
        for (int i = 1; i <= PA + 2; i++) step(1'b1, 1'b0, 1'b1, '{-2048, -2048, -2048, -2048});
        for (int c = 0; c < NCH; c++) begin
            n_tests++;
            if (lane(0, c) !== want_a) begin
                n_fail++; $display("FAIL extreme_a ch%0d: got %0d want %0d", c, lane(0, c), want_a);
            end
            n_tests++;
            if (lane(1, c) !== want_b) begin
                n_fail++; $display("FAIL extreme_b ch%0d: got %0d want %0d", c, lane(1, c), want_b);
            end
        end
        $display("[TB] test_extremes done");
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b1, '{1, 1, 1, 1});
        step(1'b1, 1'b1, 1'b1, '{1, 1, 1, 1});
        n_tests++;
        if (a_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_beat_valid: got %0b want 0", a_out_valid);
        end
        for (int i = 1; i <= PA; i++) begin
            step(1'b1, 1'b0, 1'b1, '{1, 1, 1, 1});
            n_tests++;
            if (a_out_valid !== (i == PA)) begin
                n_fail++; $display("FAIL flush_valid beat %0d after flush: got %0b want %0b", i, a_out_valid, (i == PA));
            end
        end
        for (int c = 0; c < NCH; c++) begin
            n_tests++;
            if (lane(0, c) !== exp_dat[0][c]) begin
                n_fail++; $display("FAIL flush_data ch%0d: got %0d want %0d", c, lane(0, c), exp_dat[0][c]);
            end
        end
        $display("[TB] test_flush done");
    endtask

    task automatic test_backpressure();
        int held[NCH];
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b0, !(k >= 15 && k < 20), rand_lanes());
            if (k == 14) for (int c = 0; c < NCH; c++) held[c] = lane(0, c);
            for (int d = 0; d < 2; d++) begin
                n_tests++;
                if (dut_ov(d) !== exp_ov[d]) begin
                    n_fail++; $display("FAIL bp_valid d%0d cyc %0d: got %0b want %0b", d, k, dut_ov(d), exp_ov[d]);
                end
                n_tests++;
                if (obs_rdy[d] !== exp_rdy[d]) begin
                    n_fail++; $display("FAIL bp_in_ready d%0d cyc %0d: got %0b want %0b", d, k, obs_rdy[d], exp_rdy[d]);
                end
                for (int c = 0; c < NCH; c++) begin
                    n_tests++;
                    if (lane(d, c) !== exp_dat[d][c]) begin
                        n_fail++; $display("FAIL bp_data d%0d cyc %0d ch%0d: got %0d want %0d", d, k, c, lane(d, c), exp_dat[d][c]);
                    end
                end
            end
            if (k >= 16 && k < 20) begin
                n_tests++;
                if (obs_rdy[0] !== 1'b0 || lane(0, 0) !== held[0]) begin
                    n_fail++; $display("FAIL bp_stall cyc %0d: in_ready %0b data %0d want 0 and %0d", k, obs_rdy[0], lane(0, 0), held[0]);
                end
            end
        end
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, rand_lanes());
            for (int d = 0; d < 2; d++) begin
                n_tests++;
                if (dut_ov(d) !== exp_ov[d]) begin
                    n_fail++; $display("FAIL rnd_valid d%0d cyc %0d: got %0b want %0b", d, k, dut_ov(d), exp_ov[d]);
                end
                n_tests++;
                if (obs_rdy[d] !== exp_rdy[d]) begin
                    n_fail++; $display("FAIL rnd_in_ready d%0d cyc %0d: got %0b want %0b", d, k, obs_rdy[d], exp_rdy[d]);
                end
                for (int c = 0; c < NCH; c++) begin
                    n_tests++;
                    if (lane(d, c) !== exp_dat[d][c]) begin
                        n_fail++; $display("FAIL rnd_data d%0d cyc %0d ch%0d: got %0d want %0d", d, k, c, lane(d, c), exp_dat[d][c]);
                    end
                end
            end
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b1, '{1, 1, 1, 1});
        rst = 1'b1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0;
        model_reset();
        for (int i = 1; i <= PA; i++) begin
            step(1'b1, 1'b0, 1'b1, '{1, 1, 1, 1});
            n_tests++;
            if (a_out_valid !== (i == PA)) begin
                n_fail++; $display("FAIL rstmid_valid beat %0d: got %0b want %0b", i, a_out_valid, (i == PA));
            end
        end
        $display("[TB] test_reset_mid done");
    endtask

`ifdef WINDOW_ACCUM_AVG_EN
    task automatic test_avg();
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, (i == 8) ? '{2, 2, 2, 2} : '{1, 1, 1, 1});
        for (int c = 0; c < NCH; c++) begin
            n_tests++;
            if (lane(0, c) !== 1) begin
                n_fail++; $display("FAIL avg_nine ch%0d: got %0d want 1", c, lane(0, c));
            end
        end
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, '{3, 3, 3, 3});
        for (int c = 0; c < NCH; c++) begin
            n_tests++;
            if (lane(0, c) !== 3) begin
                n_fail++; $display("FAIL avg_threes ch%0d: got %0d want 3", c, lane(0, c));
            end
        end
        $display("[TB] test_avg done");
    endtask
`endif

    initial begin
        pool_sz[0] = PA; stride_sz[0] = SA;
        pool_sz[1] = PB; stride_sz[1] = SB;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_ones();
        test_ramp();
        test_extremes();
        test_flush();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef WINDOW_ACCUM_AVG_EN
        test_avg();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
